// File: rtl/sfifo_wr_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfifo_wr_arb_if : requester / FIFO-write / credit bundle          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface sfifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    fifo_pop;
  logic                    winc;
  logic [WIDTH-1:0]        wdata;
  logic                    grant_vld;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic [$clog2(DEPTH):0]  credits;
  logic                    credit_err;

  modport master (
    output req_valid, req_data, fifo_pop,
    input  req_ready, winc, wdata, grant_vld, grant_id, credits, credit_err
  );

  modport slave (
    input  req_valid, req_data, fifo_pop,
    output req_ready, winc, wdata, grant_vld, grant_id, credits, credit_err
  );
endinterface
`default_nettype wire

// File: rtl/sfifo_wr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfifo_wr_arb : round-robin, credit-gated write arbiter for sfifo  |
// | Optional macro SFIFO_ARB_PRIO_EN: requester 0 wins arbitration.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sfifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int BURST = 4
) (
  input wire            clk,
  input wire            rst_n,
  sfifo_wr_arb_if.slave bus
);
  localparam int c_idw = $clog2(NREQ);
  localparam int c_cw  = $clog2(DEPTH) + 1;
  localparam int c_bw  = $clog2(BURST + 1);
  localparam logic [c_cw-1:0]  c_full      = c_cw'(DEPTH);
  localparam logic [c_bw-1:0]  c_last_beat = c_bw'(BURST - 1);
  localparam logic [c_idw-1:0] c_last_rst  = c_idw'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic [c_idw-1:0] r_grant_id,   w_grant_id_nxt;
  logic [c_idw-1:0] r_last_id,    w_last_id_nxt;
  logic [c_bw-1:0]  r_beat_cnt,   w_beat_cnt_nxt;
  logic [c_cw-1:0]  r_credits,    w_credits_nxt;
  logic             r_credit_err, w_credit_err_nxt;

  logic             w_granted, w_has_credit, w_gnt_valid, w_winc, w_release;
  logic [c_idw-1:0] w_arb_base, w_pick_id, w_idx;
  logic             w_pick_vld;
  logic [WIDTH-1:0] w_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_slice[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  assign w_granted    = (r_state == ST_GRANT);
  assign w_has_credit = (r_credits != '0);
  assign w_gnt_valid  = bus.req_valid[r_grant_id];
  assign w_winc       = w_granted & w_has_credit & w_gnt_valid;
  // A credit stall keeps the grant; only a final beat or a dropped valid releases.
  assign w_release    = w_granted & (~w_gnt_valid | (w_winc & (r_beat_cnt == c_last_beat)));
  // On release last_id takes grant_id, so the search starts just past the current owner.
  assign w_arb_base   = w_granted ? r_grant_id : r_last_id;

  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    w_idx      = '0;
    // Descending scan: the nearest valid requester after the base is written last.
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = c_idw'((int'(w_arb_base) + k) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = w_idx;
      end
    end
`ifdef SFIFO_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      w_pick_id = '0;
    end
`else
`endif
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_last_id_nxt  = r_last_id;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt    = ST_GRANT;
          w_grant_id_nxt = w_pick_id;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_last_id_nxt  = r_grant_id;
          w_beat_cnt_nxt = '0;
          if (w_pick_vld) begin
            w_grant_id_nxt = w_pick_id;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_winc) begin
          w_beat_cnt_nxt = r_beat_cnt + c_bw'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_credits_nxt    = r_credits;
    w_credit_err_nxt = r_credit_err;
    if (w_winc && !bus.fifo_pop) begin
      w_credits_nxt = r_credits - c_cw'(1);
    end else if (bus.fifo_pop && !w_winc) begin
      if (r_credits == c_full) begin
        w_credit_err_nxt = 1'b1;
      end else begin
        w_credits_nxt = r_credits + c_cw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_id    <= c_last_rst;
      r_beat_cnt   <= '0;
      r_credits    <= c_full;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_id    <= w_last_id_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_credits    <= w_credits_nxt;
      r_credit_err <= w_credit_err_nxt;
    end
  end

  assign bus.req_ready  = (w_granted && w_has_credit) ? (NREQ'(1) << r_grant_id) : '0;
  assign bus.winc       = w_winc;
  assign bus.wdata      = w_granted ? w_slice[r_grant_id] : '0;
  assign bus.grant_vld  = w_granted;
  assign bus.grant_id   = r_grant_id;
  assign bus.credits    = r_credits;
  assign bus.credit_err = r_credit_err;
endmodule
`default_nettype wire

// File: tb/tb_sfifo_wr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sfifo_wr_arb : scoreboard bench with a transaction-level model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_sfifo_wr_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sfifo_wr_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sfifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit              gvld;
    int              gid;
    logic [NREQ-1:0] rdy;
    bit              winc;
    logic [WIDTH-1:0] wdata;
    int              credits;
    bit              err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int dut_wr_cnt = 0;

  // Requester-side stimulus state
  logic [NREQ-1:0]  v;
  logic [WIDTH-1:0] d [NREQ];
  bit               pop;

  // Reference model: owner (-1 = none), beats taken in this grant, free slots
  int m_owner, m_beats, m_credits, m_last;
  bit m_err;

  task automatic model_reset();
    m_owner   = -1;
    m_beats   = 0;
    m_credits = DEPTH;
    m_err     = 1'b0;
    m_last    = NREQ - 1;
  endtask

  function automatic int pick(input int base);
`ifdef SFIFO_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (base + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant_vld", 64'(bus.grant_vld), 64'(e.gvld));
      if (e.gvld) chk("grant_id", 64'(bus.grant_id), 64'(e.gid));
      chk("req_ready", 64'(bus.req_ready), 64'(e.rdy));
      chk("winc", 64'(bus.winc), 64'(e.winc));
      chk("wdata", 64'(bus.wdata), 64'(e.wdata));
      chk("credits", 64'(bus.credits), 64'(e.credits));
      chk("credit_err", 64'(bus.credit_err), 64'(e.err));
      if (bus.winc === 1'b1) dut_wr_cnt++;
    end
  end

  // pop_mode: 0 none, 1 when FIFO non-empty (pop_pct), 2 forced, 3 mode 1 plus rare stray pops
  task automatic step(input logic [NREQ-1:0] allow, input int cont_pct, input int raise_pct,
                      input int pop_mode, input int pop_pct);
    exp_t e;
    logic [NREQ-1:0] acc;
    int occ;
    bit wr;
    occ = DEPTH - m_credits;
    case (pop_mode)
      0:       pop = 1'b0;
      1:       pop = (occ > 0) && ($urandom_range(99) < pop_pct);
      2:       pop = 1'b1;
      default: pop = ((occ > 0) && ($urandom_range(99) < pop_pct)) || ($urandom_range(99) < 2);
    endcase
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = d[i];
    bus.fifo_pop = pop;

    e.gvld  = (m_owner >= 0);
    e.gid   = e.gvld ? m_owner : 0;
    e.rdy   = '0;
    e.wdata = '0;
    if (m_owner >= 0) begin
      if (m_credits > 0) e.rdy[m_owner] = 1'b1;
      e.wdata = d[m_owner];
    end
    acc       = e.rdy & v;
    wr        = (acc != '0);
    e.winc    = wr;
    e.credits = m_credits;
    e.err     = m_err;
    exp_q.push_back(e);

    @(posedge clk);
    if (rst_n) begin
      if (wr && !pop) m_credits--;
      else if (pop && !wr) begin
        if (m_credits == DEPTH) m_err = 1'b1;
        else m_credits++;
      end
      if (m_owner >= 0) begin
        if (wr) m_beats++;
        if ((wr && m_beats == BURST) || !v[m_owner]) begin
          m_last  = m_owner;
          m_owner = pick(m_last);
          m_beats = 0;
        end
      end else begin
        m_owner = pick(m_last);
        m_beats = 0;
      end
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (allow[i] && ($urandom_range(99) < cont_pct)) d[i] = WIDTH'($urandom);
        else v[i] = 1'b0;
      end else if (!v[i] && allow[i] && ($urandom_range(99) < raise_pct)) begin
        v[i] = 1'b1;
        d[i] = WIDTH'($urandom);
      end
    end
  endtask

  task automatic drain();
    v = '0;
    repeat (40) step('0, 0, 0, 1, 100);
    chk("drained_credits", 64'(bus.credits), 64'(DEPTH));
  endtask

  int w0;

  initial begin
    v = '0;
    pop = 1'b0;
    for (int i = 0; i < NREQ; i++) d[i] = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_pop  = 1'b0;
    model_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step('0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step('0, 0, 0, 0, 0);

    // All requesters streaming, consumer popping: back-to-back bursts
    v = '1;
    for (int i = 0; i < NREQ; i++) d[i] = WIDTH'($urandom);
    w0 = dut_wr_cnt;
    repeat (40) step('1, 100, 0, 1, 100);
    chk("stream_writes", 64'(dut_wr_cnt - w0), 64'd39);
    drain();

    // Single requester, no pops: credit exhaustion then one returned credit
    v = 4'b0100;
    d[2] = WIDTH'($urandom);
    w0 = dut_wr_cnt;
    repeat (20) step(4'b0100, 100, 0, 0, 0);
    chk("fill_writes", 64'(dut_wr_cnt - w0), 64'(DEPTH));
    chk("stall_ready", 64'(bus.req_ready), 64'd0);
    chk("stall_credits", 64'(bus.credits), 64'd0);
    step(4'b0100, 100, 0, 2, 0);
    step(4'b0100, 100, 0, 0, 0);
    step(4'b0100, 100, 0, 0, 0);
    chk("refill_writes", 64'(dut_wr_cnt - w0), 64'(DEPTH + 1));
    chk("refill_credits", 64'(bus.credits), 64'd0);
    drain();

    // Pop with every slot free: sticky error, credits saturate
    step('0, 0, 0, 2, 0);
    repeat (3) step('0, 0, 0, 0, 0);
    chk("credit_err_sticky", 64'(bus.credit_err), 64'd1);
    chk("credit_sat", 64'(bus.credits), 64'(DEPTH));

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        rst_n = 1'b0;
        model_reset();
        step('1, 60, 40, 0, 0);
        rst_n = 1'b1;
      end
      step('1, 60, 40, 3, 55);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
